// File: rtl/mips_arb_pkg.sv
// Shared types for the Harvard-core memory arbiter.
// The state enum is common to the top and its helpers.
package mips_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      DREAD,
      DWRITE,
      COMMIT,
      HALT
   } arb_state_t;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mips_arb_waitcnt.sv
// Wait-request cycle counter for one bus transfer.
// Raises a sticky timeout once the count reaches the limit.
module mips_arb_waitcnt #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic waiting,
   output logic timeout
);

   localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q, cnt_d;
   logic         timeout_q, timeout_d;

   // Counter parks at the limit so a long stall cannot wrap it.
   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (clear) begin
         cnt_d = '0;
      end else if (waiting && cnt_q != LIMIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == LIMIT) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Sequences a Harvard MIPS core onto one unified memory port:
// fetch, decode, optional data access, then a one-cycle commit strobe.
module mips_mem_arbiter
   import mips_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_active,
   input  logic [31:0]      cpu_instr_address,
   input  logic [31:0]      cpu_data_address,
   input  logic             cpu_data_read,
   input  logic             cpu_data_write,
   input  logic [31:0]      cpu_data_writedata,
   output logic [31:0]      cpu_instr_readdata,
   output logic [31:0]      cpu_data_readdata,
   output logic             cpu_clock_enable,
   output logic [31:0]      mem_address,
   output logic             mem_read,
   output logic             mem_write,
   output logic [31:0]      mem_writedata,
   input  logic [31:0]      mem_readdata,
   input  logic             mem_waitrequest,
   output logic [CNT_W-1:0] stall_count,
   output logic             bus_timeout,
   output logic             protocol_error
);

   arb_state_t       state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      daddr_q, daddr_d;
   logic [31:0]      dwdata_q, dwdata_d;
   logic             ce_q, ce_d;
   logic             perr_q, perr_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             xfer;

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      rdata_d  = rdata_q;
      daddr_d  = daddr_q;
      dwdata_d = dwdata_q;
      perr_d   = perr_q;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (!mem_waitrequest) begin
               instr_d = mem_readdata;
               state_d = DECODE;
            end
         end
         DECODE: begin
            daddr_d  = cpu_data_address & ALIGN_MASK;
            dwdata_d = cpu_data_writedata;
            if (cpu_data_read) begin
               state_d = DREAD;
               if (cpu_data_write) perr_d = 1'b1;
            end else if (cpu_data_write) begin
               state_d = DWRITE;
            end else begin
               state_d = COMMIT;
            end
         end
         DREAD: begin
            if (!mem_waitrequest) begin
               rdata_d = mem_readdata;
               state_d = COMMIT;
            end
         end
         DWRITE: begin
            if (!mem_waitrequest) state_d = COMMIT;
         end
         COMMIT: state_d = cpu_active ? FETCH : HALT;
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
      ce_d    = (state_d == COMMIT);
      stall_d = stall_q;
      if (!ce_q && state_q != HALT && stall_q != '1)
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         rdata_q  <= '0;
         daddr_q  <= '0;
         dwdata_q <= '0;
         ce_q     <= 1'b0;
         perr_q   <= 1'b0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         rdata_q  <= rdata_d;
         daddr_q  <= daddr_d;
         dwdata_q <= dwdata_d;
         ce_q     <= ce_d;
         perr_q   <= perr_d;
         stall_q  <= stall_d;
      end
   end

   // Bus strobes decode straight from state so a request is
   // visible in the same cycle the state is entered.
   always_comb begin
      mem_address   = '0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_writedata = dwdata_q;
      unique case (state_q)
         FETCH: begin
            mem_address = cpu_instr_address & ALIGN_MASK;
            mem_read    = 1'b1;
         end
         DREAD: begin
            mem_address = daddr_q;
            mem_read    = 1'b1;
         end
         DWRITE: begin
            mem_address = daddr_q;
            mem_write   = 1'b1;
         end
         default: ;
      endcase
   end

   assign xfer = mem_read | mem_write;

   mips_arb_waitcnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_waitcnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (xfer & ~mem_waitrequest),
      .waiting(xfer & mem_waitrequest),
      .timeout(bus_timeout)
   );

   assign cpu_instr_readdata = instr_q;
   assign cpu_data_readdata  = rdata_q;
   assign cpu_clock_enable   = ce_q;
   assign stall_count        = stall_q;
   assign protocol_error     = perr_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scenario bench for mips_mem_arbiter: expected bus transfers are
// queued per scenario and matched as the arbiter completes them.
module tb_mips_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_active;
   logic [31:0] cpu_instr_address;
   logic [31:0] cpu_data_address;
   logic        cpu_data_read;
   logic        cpu_data_write;
   logic [31:0] cpu_data_writedata;
   logic [31:0] cpu_instr_readdata;
   logic [31:0] cpu_data_readdata;
   logic        cpu_clock_enable;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;
   logic [31:0] stall_count;
   logic        bus_timeout;
   logic        protocol_error;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } txn_t;

   txn_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mips_mem_arbiter #(
      .TIMEOUT_CYCLES(8),
      .CNT_W         (32)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .cpu_active        (cpu_active),
      .cpu_instr_address (cpu_instr_address),
      .cpu_data_address  (cpu_data_address),
      .cpu_data_read     (cpu_data_read),
      .cpu_data_write    (cpu_data_write),
      .cpu_data_writedata(cpu_data_writedata),
      .cpu_instr_readdata(cpu_instr_readdata),
      .cpu_data_readdata (cpu_data_readdata),
      .cpu_clock_enable  (cpu_clock_enable),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_readdata      (mem_readdata),
      .mem_waitrequest   (mem_waitrequest),
      .stall_count       (stall_count),
      .bus_timeout       (bus_timeout),
      .protocol_error    (protocol_error)
   );

   task automatic push(input logic [31:0] a, input logic w,
                       input logic [31:0] d);
      txn_t t;
      t.addr = a;
      t.wr   = w;
      t.data = d;
      exp_q.push_back(t);
   endtask

   // Advance one cycle; a transfer accepted at this edge is scored first.
   task automatic tick();
      txn_t t;
      if ((mem_read || mem_write) && !mem_waitrequest) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected addr=%h rd=%b wr=%b",
                     mem_address, mem_read, mem_write);
         end else begin
            t = exp_q.pop_front();
            if (mem_address !== t.addr || mem_write !== t.wr ||
                mem_read !== !t.wr ||
                (t.wr && mem_writedata !== t.data)) begin
               errors++;
               $display("FAIL bus_txn got a=%h rd=%b wr=%b d=%h exp a=%h wr=%b d=%h",
                        mem_address, mem_read, mem_write, mem_writedata,
                        t.addr, t.wr, t.data);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_q.delete();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] got;
      apply_reset();
      got = {mem_read, mem_write, cpu_clock_enable, bus_timeout,
             protocol_error, 27'd0};
      checks++;
      if (got !== 32'd0) begin
         errors++;
         $display("FAIL reset_flags got=%h exp=0", got);
      end
      checks++;
      if (cpu_instr_readdata !== 0 || cpu_data_readdata !== 0) begin
         errors++;
         $display("FAIL reset_data got=%h/%h exp=0",
                  cpu_instr_readdata, cpu_data_readdata);
      end
      checks++;
      if (stall_count !== 0) begin
         errors++;
         $display("FAIL reset_stall got=%0d exp=0", stall_count);
      end
   endtask

   task automatic test_alu();
      cpu_instr_address = 32'hBFC0_0000;
      mem_readdata      = 32'h0123_4567;
      push(32'hBFC0_0000, 1'b0, 32'h0);
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'hBFC0_0000 ||
          cpu_clock_enable !== 1'b0) begin
         errors++;
         $display("FAIL alu_fetch rd=%b a=%h ce=%b exp 1/bfc00000/0",
                  mem_read, mem_address, cpu_clock_enable);
      end
      tick();
      checks++;
      if (mem_read !== 1'b0 || cpu_clock_enable !== 1'b0 ||
          cpu_instr_readdata !== 32'h0123_4567) begin
         errors++;
         $display("FAIL alu_decode rd=%b ce=%b ir=%h exp 0/0/01234567",
                  mem_read, cpu_clock_enable, cpu_instr_readdata);
      end
      tick();
      checks++;
      if (cpu_clock_enable !== 1'b1 || stall_count !== 32'd3) begin
         errors++;
         $display("FAIL alu_commit ce=%b stall=%0d exp 1/3",
                  cpu_clock_enable, stall_count);
      end
      cpu_instr_address = 32'hBFC0_0004;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'hBFC0_0004 ||
          cpu_clock_enable !== 1'b0 || stall_count !== 32'd3) begin
         errors++;
         $display("FAIL alu_next_fetch rd=%b a=%h ce=%b stall=%0d exp 1/bfc00004/0/3",
                  mem_read, mem_address, cpu_clock_enable, stall_count);
      end
   endtask

   task automatic test_load();
      mem_readdata     = 32'h8C00_0000;
      cpu_data_read    = 1'b1;
      cpu_data_address = 32'h0000_1006;
      push(32'hBFC0_0004, 1'b0, 32'h0);
      push(32'h0000_1004, 1'b0, 32'h0);
      tick();
      mem_readdata    = 32'hDEAD_BEEF;
      mem_waitrequest = 1'b1;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0000_1004) begin
         errors++;
         $display("FAIL load_addr rd=%b a=%h exp 1/00001004",
                  mem_read, mem_address);
      end
      cpu_data_address = 32'h0000_5555;
      cpu_data_read    = 1'b0;
      tick();
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0000_1004) begin
         errors++;
         $display("FAIL load_hold rd=%b a=%h exp 1/00001004",
                  mem_read, mem_address);
      end
      mem_waitrequest = 1'b0;
      tick();
      checks++;
      if (cpu_clock_enable !== 1'b1 || cpu_data_readdata !== 32'hDEAD_BEEF ||
          stall_count !== 32'd8) begin
         errors++;
         $display("FAIL load_commit ce=%b rd=%h stall=%0d exp 1/deadbeef/8",
                  cpu_clock_enable, cpu_data_readdata, stall_count);
      end
      cpu_instr_address = 32'hBFC0_0008;
      tick();
   endtask

   task automatic test_store();
      mem_readdata       = 32'hAC00_0000;
      cpu_data_write     = 1'b1;
      cpu_data_address   = 32'h0000_2000;
      cpu_data_writedata = 32'h1234_5678;
      push(32'hBFC0_0008, 1'b0, 32'h0);
      push(32'h0000_2000, 1'b1, 32'h1234_5678);
      tick();
      tick();
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
          mem_writedata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL store_bus wr=%b rd=%b d=%h exp 1/0/12345678",
                  mem_write, mem_read, mem_writedata);
      end
      tick();
      checks++;
      if (cpu_clock_enable !== 1'b1 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL store_commit ce=%b wr=%b exp 1/0",
                  cpu_clock_enable, mem_write);
      end
      cpu_data_write    = 1'b0;
      cpu_instr_address = 32'hBFC0_000C;
      tick();
   endtask

   task automatic test_protocol();
      mem_readdata     = 32'h0000_0020;
      cpu_data_read    = 1'b1;
      cpu_data_write   = 1'b1;
      cpu_data_address = 32'h0000_3008;
      push(32'hBFC0_000C, 1'b0, 32'h0);
      push(32'h0000_3008, 1'b0, 32'h0);
      tick();
      mem_readdata = 32'hCAFE_F00D;
      tick();
      checks++;
      if (protocol_error !== 1'b1 || mem_write !== 1'b0 ||
          mem_read !== 1'b1) begin
         errors++;
         $display("FAIL proto_dread perr=%b wr=%b rd=%b exp 1/0/1",
                  protocol_error, mem_write, mem_read);
      end
      tick();
      checks++;
      if (protocol_error !== 1'b1 || cpu_data_readdata !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL proto_commit perr=%b rd=%h exp 1/cafef00d",
                  protocol_error, cpu_data_readdata);
      end
      cpu_data_read     = 1'b0;
      cpu_data_write    = 1'b0;
      cpu_instr_address = 32'hBFC0_0010;
      tick();
   endtask

   task automatic test_timeout();
      mem_waitrequest = 1'b1;
      for (int i = 1; i <= 7; i++) tick();
      checks++;
      if (bus_timeout !== 1'b0 || mem_read !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early to=%b rd=%b exp 0/1",
                  bus_timeout, mem_read);
      end
      tick();
      checks++;
      if (bus_timeout !== 1'b1 || mem_read !== 1'b1) begin
         errors++;
         $display("FAIL timeout_set to=%b rd=%b exp 1/1",
                  bus_timeout, mem_read);
      end
      mem_waitrequest = 1'b0;
      push(32'hBFC0_0010, 1'b0, 32'h0);
      tick();
      checks++;
      if (bus_timeout !== 1'b1 || protocol_error !== 1'b1) begin
         errors++;
         $display("FAIL sticky_flags to=%b perr=%b exp 1/1",
                  bus_timeout, protocol_error);
      end
   endtask

   task automatic test_reset_mid();
      cpu_data_read    = 1'b1;
      cpu_data_address = 32'h0000_4000;
      mem_waitrequest  = 1'b1;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0000_4000) begin
         errors++;
         $display("FAIL mid_dread rd=%b a=%h exp 1/00004000",
                  mem_read, mem_address);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 ||
          cpu_clock_enable !== 1'b0 || bus_timeout !== 1'b0 ||
          protocol_error !== 1'b0 || stall_count !== 0 ||
          cpu_instr_readdata !== 0 || cpu_data_readdata !== 0) begin
         errors++;
         $display("FAIL mid_reset rd=%b wr=%b ce=%b to=%b pe=%b st=%0d exp all 0",
                  mem_read, mem_write, cpu_clock_enable, bus_timeout,
                  protocol_error, stall_count);
      end
      exp_q.delete();
      reset             = 1'b1;
      cpu_data_read     = 1'b0;
      mem_waitrequest   = 1'b0;
      cpu_instr_address = 32'h0040_0000;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0040_0000) begin
         errors++;
         $display("FAIL restart_fetch rd=%b a=%h exp 1/00400000",
                  mem_read, mem_address);
      end
   endtask

   task automatic test_halt();
      int bad = 0;
      cpu_active = 1'b0;
      push(32'h0040_0000, 1'b0, 32'h0);
      tick();
      tick();
      checks++;
      if (cpu_clock_enable !== 1'b1) begin
         errors++;
         $display("FAIL halt_commit ce=%b exp 1", cpu_clock_enable);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_read !== 1'b0 || mem_write !== 1'b0 ||
             cpu_clock_enable !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_quiet busy_cycles=%0d exp 0", bad);
      end
      checks++;
      if (stall_count !== 32'd3) begin
         errors++;
         $display("FAIL halt_stall got=%0d exp 3", stall_count);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_txns got=%0d exp 0", exp_q.size());
      end
   endtask

   initial begin
      reset              = 1'b0;
      cpu_active         = 1'b1;
      cpu_instr_address  = 32'h0;
      cpu_data_address   = 32'h0;
      cpu_data_read      = 1'b0;
      cpu_data_write     = 1'b0;
      cpu_data_writedata = 32'h0;
      mem_readdata       = 32'h0;
      mem_waitrequest    = 1'b0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_protocol();
      test_timeout();
      test_reset_mid();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Sequences the Harvard CPU core onto a single unified memory port with wait-request handshake.
- Each instruction: fetch, let the core decode, optionally perform one data access, then pulse the core's clock_enable for one cycle so it commits.
- Sits between mips_cpu_harvard and the shared memory/bus model.
- Also provides a stall-cycle counter and sticky error flags for the test harness.

Parameters:
- TIMEOUT_CYCLES, 1024, consecutive wait-request cycles in one transfer before bus_timeout is set.
- CNT_W, 32, width of stall_count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- cpu_active  input  1  core's active output
- cpu_instr_address  input  32  fetch address from core
- cpu_data_address  input  32  data address from core
- cpu_data_read  input  1  core data read request
- cpu_data_write  input  1  core data write request
- cpu_data_writedata  input  32  core store data
- cpu_instr_readdata  output  32  latched instruction word to core
- cpu_data_readdata  output  32  latched load data to core
- cpu_clock_enable  output  1  one-cycle commit strobe to core
- mem_address  output  32  unified memory address
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_writedata  output  32  memory write data
- mem_readdata  input  32  memory read data, valid when mem_read=1 and mem_waitrequest=0
- mem_waitrequest  input  1  memory not ready; hold request stable
- stall_count  output  CNT_W  cycles since reset with cpu_clock_enable=0 and state not HALT
- bus_timeout  output  1  sticky timeout flag
- protocol_error  output  1  sticky flag: read and write requested together

Behaviour:
- Reset: reset=0 sampled at a posedge forces the following, regardless of state or pending transfer (an in-flight transfer is abandoned):
  - state=IDLE
  - mem_read=0, mem_write=0, cpu_clock_enable=0
  - cpu_instr_readdata=0, cpu_data_readdata=0
  - stall_count=0, bus_timeout=0, protocol_error=0, wait counter=0
- All outputs are registered, except mem_address, mem_read, mem_write and mem_writedata, which are decoded from the state register plus the latched address/data.
- States (shared enum):
  - IDLE: next FETCH.
  - FETCH:
    - mem_address={cpu_instr_address[31:2],2'b00}, mem_read=1.
    - On mem_waitrequest=0: latch mem_readdata into cpu_instr_readdata, go to DECODE.
  - DECODE: one settle cycle so the core decodes the new word combinationally. Sample cpu_data_* at the end of the cycle:
    - read=1, write=0 -> DREAD.
    - write=1, read=0 -> DWRITE.
    - both=1 -> set protocol_error, go DREAD.
    - neither -> COMMIT.
  - DREAD:
    - mem_address=latched cpu_data_address with low two bits cleared, mem_read=1.
    - On waitrequest=0: latch cpu_data_readdata, go to COMMIT.
  - DWRITE:
    - mem_address=latched aligned address, mem_write=1, mem_writedata=latched cpu_data_writedata.
    - On waitrequest=0: go to COMMIT.
  - COMMIT:
    - cpu_clock_enable=1 for exactly this cycle.
    - Next state: if cpu_active=0, HALT; else FETCH.
  - HALT: no memory activity; cpu_clock_enable=0; exit only via reset.
- Data address, read/write flags and writedata are latched at the DECODE exit edge and held constant through DREAD/DWRITE even if core outputs change.
- mem_read and mem_write are never both 1 in the same cycle.
- Wait handling:
  - Request signals are held stable while mem_waitrequest=1.
  - The wait counter increments on each waited cycle and clears on transfer completion.
  - When it reaches TIMEOUT_CYCLES, bus_timeout is set (sticky) and the transfer keeps waiting.
- Latency with zero-wait memory:
  - 3 cycles per instruction without data access (FETCH, DECODE, COMMIT).
  - 4 cycles per load or store.
- stall_count saturates at all-ones.

Decomposition:
- mips_arb_pkg:
  - arb_state_t enum (IDLE, FETCH, DECODE, DREAD, DWRITE, COMMIT, HALT).
  - ALIGN_MASK constant 32'hFFFF_FFFC.
- Sub-module mips_arb_waitcnt: wait counter plus sticky timeout flag, with inputs clear, waiting and TIMEOUT_CYCLES.

Test Plan:
- Zero-wait ALU op: instr at 0xBFC00000, cpu_data_read=cpu_data_write=0 -> mem_read high 1 cycle at 0xBFC00000; cpu_clock_enable high in cycle 3; next fetch in cycle 4.
- Load with 2 wait cycles on data: cpu_data_read=1, address 0x1006, mem returns 0xDEADBEEF -> mem_address=0x1004; cpu_data_readdata=0xDEADBEEF; commit 6 cycles after fetch start; stall_count +5.
- Store: cpu_data_write=1, address 0x2000, data 0x12345678 -> single cycle with mem_write=1, mem_writedata=0x12345678, mem_read=0; then commit.
- Read and write both set in DECODE -> protocol_error=1 and stays 1; a read is performed; no mem_write.
- mem_waitrequest held high with TIMEOUT_CYCLES=8 -> bus_timeout rises after the 8th waited cycle; mem_read remains 1.
- Reset low mid-DREAD -> next cycle mem_read=0, all outputs 0; after release, a fetch restarts at the current cpu_instr_address.
- cpu_active=0 at COMMIT -> HALT; no further mem_read or mem_write; stall_count frozen.
